// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// MULTDIV_DIVIDE_EN selects whether the DIV/DIVU datapath is built.
package multdiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

`ifdef MULTDIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// The divide half exists only when MULTDIV_DIVIDE_EN is defined.
module multdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH:0]   opnd_i,
  input  logic             div_i,
  output logic [2*WIDTH:0] acc_o,
  output logic             q_o
);

  // Multiply: upper WIDTH+1 bits accumulate, lower bits hold the unconsumed multiplier.
  logic [WIDTH:0] sum;

`ifdef MULTDIV_DIVIDE_EN
  // Divide: upper bits are the partial remainder, lower bits shift dividend out / quotient in.
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
`else
  logic unused_div;
  assign unused_div = div_i;
`endif

  always_comb begin
    sum   = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? opnd_i : '0);
    acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    q_o   = 1'b0;
`ifdef MULTDIV_DIVIDE_EN
    trial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff  = {1'b0, trial} - {1'b0, opnd_i};
    if (div_i) begin
      q_o   = ~diff[WIDTH+1];
      acc_o = {(diff[WIDTH+1] ? trial : diff[WIDTH:0]), acc_i[WIDTH-2:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// MULT/MULTU/DIV/DIVU controller writing HI/LO over WIDTH iterations.
// Divide support is built only when MULTDIV_DIVIDE_EN is defined.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero,
  output state_e           State
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]     opnd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q, rem_neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dbz_q;

  logic               sgn, a_neg, b_neg;
  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
  logic [2*WIDTH:0]   step_acc;
  logic               step_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // Magnitudes are WIDTH+1 bits so that the most negative operand has a representable absolute value.
  always_comb begin
    sgn   = is_signed_op(op_q);
    a_neg = sgn & a_q[WIDTH-1];
    b_neg = sgn & b_q[WIDTH-1];
    a_ext = {a_neg, a_q};
    b_ext = {b_neg, b_q};
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    prod  = acc_q[2*WIDTH-1:0];
    quo   = acc_q[WIDTH-1:0];
    rem   = acc_q[2*WIDTH-1:WIDTH];
    acc_d = step_acc | {{(2*WIDTH){1'b0}}, step_q};
  end

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div(op_q)),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            op_q <= op_e'(Op);
            a_q  <= A;
            b_q  <= B;
            if (!DIV_EN && is_div(Op)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_PREP;
              busy_q  <= 1'b1;
            end
          end
        end
        S_PREP: begin
          if (DIV_EN && is_div(op_q) && (b_q == '0)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
          end else begin
            state_q   <= S_ITER;
            cnt_q     <= CNT_W'(WIDTH);
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            if (is_div(op_q)) begin
              acc_q  <= {{(WIDTH+1){1'b0}}, a_mag[WIDTH-1:0]};
              opnd_q <= b_mag;
            end else begin
              acc_q  <= {{(WIDTH+1){1'b0}}, b_mag[WIDTH-1:0]};
              opnd_q <= a_mag;
            end
          end
        end
        S_ITER: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          if (DIV_EN && is_div(op_q)) begin
            lo_q <= neg_q ? -quo : quo;
            hi_q <= rem_neg_q ? -rem : rem;
          end else begin
            {hi_q, lo_q} <= neg_q ? -prod : prod;
          end
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Stall     = busy_q & HiLoRead;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign State     = state_q;

endmodule
